// File: rtl/result_uart_tx.sv
// Frames the 730/850 nm maxima into a 5-byte packet (sync, 3 data bytes, XOR check) sent as async serial, LSB first.
// Start bit appears the cycle after an accepted load; load is ignored while busy, and done overlaps the last stop cycle.
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] max730,
  input  logic [11:0] max850,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PENULT = CW'(CLKS_PER_BIT - 2);
  localparam logic          STOP_LAST   = (STOP_BITS == 2);
  localparam logic [2:0]    BYTE_LAST   = 3'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic          stop_cnt;
  logic [11:0]   lat730;
  logic [11:0]   lat850;
  logic [7:0]    cur_byte;
  logic          baud_end;

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      3'd1:    cur_byte = lat730[11:4];
      3'd2:    cur_byte = {lat730[3:0], lat850[11:8]};
      3'd3:    cur_byte = lat850[7:0];
      3'd4:    cur_byte = lat730[11:4] ^ {lat730[3:0], lat850[11:8]} ^ lat850[7:0];
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      stop_cnt <= 1'b0;
      lat730   <= '0;
      lat850   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (load) begin
            lat730   <= max730;
            lat850   <= max850;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            stop_cnt <= 1'b0;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          // Leave one cycle early so done/busy=0 land on the final stop cycle,
          // letting a load in that cycle start the next packet with no gap.
          if (byte_idx == BYTE_LAST && stop_cnt == STOP_LAST && baud_cnt == BAUD_PENULT) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            baud_cnt <= '0;
            byte_idx <= '0;
            stop_cnt <= 1'b0;
          end else if (baud_end) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              stop_cnt <= 1'b0;
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: one DUT with 1 stop bit, one with 2, decoded by a cycle-accurate receiver.
module tb_result_uart_tx;

  localparam int C = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load1;
  logic        load2;
  logic [11:0] m730;
  logic [11:0] m850;
  logic        tx1, busy1, done1;
  logic        tx2, busy2, done2;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1), .SYNC_BYTE(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .max730(m730), .max850(m850),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  result_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2), .SYNC_BYTE(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load2), .max730(m730), .max850(m850),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push5(input logic [39:0] bytes);
    for (int i = 4; i >= 0; i--) sb.push_back(bytes[i*8 +: 8]);
  endtask

  // Called on a negedge; returns on the negedge of the first start-bit cycle.
  task automatic launch(input int sel, input logic [11:0] a, input logic [11:0] b);
    m730 = a;
    m850 = b;
    if (sel != 0) load2 = 1'b1; else load1 = 1'b1;
    @(negedge clk);
    load1 = 1'b0;
    load2 = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    int err;
    err = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({tx1, busy1, done1, tx2, busy2, done2} !== 6'b100100) err++;
    end
    chk(tag, 32'(err), 0);
  endtask

  // First sample is taken at the current negedge (first start-bit cycle).
  // When chain is set, a new load is driven during the done cycle.
  task automatic rx_packet(input int sel, input int s, input bit chain,
                           input logic [11:0] ca, input logic [11:0] cb,
                           input logic [39:0] cexp, input string tag);
    int nb, frame_err, busy_err, done_err;
    logic t, bz, dn, first;
    logic [7:0] got, exp;
    nb = (9 + s) * C;
    frame_err = 0;
    busy_err = 0;
    done_err = 0;
    first = 1'b0;
    for (int k = 0; k < 5; k++) begin
      got = '0;
      for (int j = 0; j < nb; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        t  = (sel != 0) ? tx2 : tx1;
        bz = (sel != 0) ? busy2 : busy1;
        dn = (sel != 0) ? done2 : done1;
        if (j % C == 0) first = t;
        else if (t !== first) frame_err++;
        if (j < C) begin
          if (t !== 1'b0) frame_err++;
        end else if (j < 9 * C) begin
          if (j % C == 0) got[3'(j / C - 1)] = t;
        end else if (t !== 1'b1) begin
          frame_err++;
        end
        if (k == 4 && j == nb - 1) begin
          if (bz !== 1'b0) busy_err++;
          if (dn !== 1'b1) done_err++;
          if (chain) begin
            m730 = ca;
            m850 = cb;
            if (sel != 0) load2 = 1'b1; else load1 = 1'b1;
            push5(cexp);
          end
        end else begin
          if (bz !== 1'b1) busy_err++;
          if (dn !== 1'b0) done_err++;
        end
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk($sformatf("%s byte%0d", tag, k), 32'(got), 32'(exp));
    end
    chk({tag, " framing"}, 32'(frame_err), 0);
    chk({tag, " busy"}, 32'(busy_err), 0);
    chk({tag, " done"}, 32'(done_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    load1 = 1'b0;
    load2 = 1'b0;
    m730  = '0;
    m850  = '0;

    // Reset state, then a long idle stretch
    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({tx1, busy1, done1, tx2, busy2, done2}), 32'(6'b100100));
    rst_n = 1'b1;
    idle_check(50, "idle after reset");

    // Basic packet, with an ignored load mid-frame and inputs changing under it
    launch(0, 12'h123, 12'h456);
    push5(40'hA512345670);
    fork
      rx_packet(0, 1, 1'b0, 12'h0, 12'h0, 40'h0, "basic");
      begin
        repeat (60) @(negedge clk);
        m730  = 12'hABC;
        m850  = 12'h999;
        load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
      end
    join
    idle_check(30, "no packet after busy load");

    // Extreme values
    launch(0, 12'hFFF, 12'h000);
    push5(40'hA5FFF0000F);
    rx_packet(0, 1, 1'b0, 12'h0, 12'h0, 40'h0, "extreme");
    idle_check(5, "idle after extreme");

    // Back-to-back, one stop bit
    launch(0, 12'h123, 12'h456);
    push5(40'hA512345670);
    rx_packet(0, 1, 1'b1, 12'h001, 12'h002, 40'hA500100212, "b2b first");
    @(negedge clk);
    load1 = 1'b0;
    rx_packet(0, 1, 1'b0, 12'h0, 12'h0, 40'h0, "b2b second");
    idle_check(5, "idle after b2b");

    // Back-to-back, two stop bits (220-cycle packets)
    launch(1, 12'h123, 12'h456);
    push5(40'hA512345670);
    rx_packet(1, 2, 1'b1, 12'h001, 12'h002, 40'hA500100212, "stop2 first");
    @(negedge clk);
    load2 = 1'b0;
    rx_packet(1, 2, 1'b0, 12'h0, 12'h0, 40'h0, "stop2 second");
    idle_check(5, "idle after stop2");

    // Reset during data bit 3 of byte 2 (cycle 98), with a load that must lose to reset
    launch(0, 12'h123, 12'h456);
    repeat (97) @(negedge clk);
    chk("mid b2 bit3 tx", 32'(tx1), 0);
    chk("mid b2 busy", 32'(busy1), 1);
    rst_n = 1'b0;
    m730  = 12'hFFF;
    load1 = 1'b1;
    @(negedge clk);
    chk("reset mid-packet", 32'({tx1, busy1, done1}), 32'(3'b100));
    rst_n = 1'b1;
    load1 = 1'b0;
    idle_check(40, "idle after mid reset");

    // Fresh packet after reset
    launch(0, 12'h7A5, 12'h3C9);
    push5(40'hA57A53C9E0);
    rx_packet(0, 1, 1'b0, 12'h0, 12'h0, 40'h0, "fresh");
    idle_check(5, "idle at end");
    chk("scoreboard drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
